// File: rtl/sbox_seq_pkg.sv
// ============================================================================
// sbox_seq_pkg : shared types and helpers for the sequential SubBytes engine
// Rev 1.0
// ============================================================================
`default_nettype none

package sbox_seq_pkg;

   localparam int NBYTES = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   function automatic int ncyc(input int lanes);
      return NBYTES / lanes;
   endfunction

   function automatic int step_width(input int lanes);
      int n;
      n = NBYTES / lanes;
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic bit lanes_legal(input int lanes);
      return (lanes == 1) || (lanes == 2) || (lanes == 4) ||
             (lanes == 8) || (lanes == 16);
   endfunction

endpackage

`default_nettype wire

// File: rtl/bSbox.sv
// ============================================================================
// bSbox : combinational AES S-box / inverse S-box, one byte, select by encrypt
// Rev 1.0
// ============================================================================
`default_nettype none

module bSbox (
   input  logic [7:0] a,
   input  logic       encrypt,
   output logic [7:0] q
);

   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] acc;
      logic [7:0] s;
      acc = 8'h00;
      s   = x;
      for (int i = 0; i < 8; i++) begin
         if (y[i]) acc = acc ^ s;
         s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
      end
      return acc;
   endfunction

   // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] r;
      logic [7:0] p;
      r = 8'h01;
      p = x;
      for (int i = 0; i < 8; i++) begin
         if (i != 0) r = gf_mul(r, p);
         p = gf_mul(p, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      logic [15:0] d;
      d = {x, x} << n;
      return d[15:8];
   endfunction

   logic [7:0] fwd_inv;
   logic [7:0] fwd_out;
   logic [7:0] inv_aff;
   logic [7:0] inv_out;

   always_comb begin
      fwd_inv = gf_inv(a);
      fwd_out = fwd_inv ^ rotl(fwd_inv, 1) ^ rotl(fwd_inv, 2) ^
                rotl(fwd_inv, 3) ^ rotl(fwd_inv, 4) ^ 8'h63;
      inv_aff = rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05;
      inv_out = gf_inv(inv_aff);
      q       = encrypt ? fwd_out : inv_out;
   end

endmodule

`default_nettype wire

// File: rtl/sbox_subbytes_seq_lane_bank.sv
// ============================================================================
// sbox_lane_bank : LANES S-boxes with step-indexed byte gather and scatter
// Rev 1.0
// ============================================================================
`default_nettype none

module sbox_lane_bank
   import sbox_seq_pkg::*;
#(
   parameter int LANES = 1,
   parameter int SW    = 4
) (
   input  logic                  encrypt,
   input  logic [SW-1:0]         rd_step,
   input  logic [127:0]          work,
   input  logic [SW-1:0]         wr_step,
   input  logic [LANES*8-1:0]    wr_bytes,
   output logic [LANES*8-1:0]    rd_bytes,
   output logic [127:0]          merged
);

   localparam int BW   = LANES * 8;
   localparam int NCYC = ncyc(LANES);

   logic [BW-1:0] group;

   always_comb begin
      group = work[int'(rd_step) * BW +: BW];
   end

   genvar j;
   generate
      for (j = 0; j < LANES; j++) begin : g_lane
         bSbox u_sbox (
            .a       (group[j*8 +: 8]),
            .encrypt (encrypt),
            .q       (rd_bytes[j*8 +: 8])
         );
      end
   endgenerate

   always_comb begin
      merged = work;
      for (int k = 0; k < NCYC; k++) begin
         if (wr_step == SW'(k)) merged[k*BW +: BW] = wr_bytes;
      end
   end

endmodule

`default_nettype wire

// File: rtl/sbox_subbytes_seq.sv
// ============================================================================
// sbox_subbytes_seq : time-multiplexed SubBytes/InvSubBytes over a 128b state
// Rev 1.0
// ============================================================================
`default_nettype none

module sbox_subbytes_seq
   import sbox_seq_pkg::*;
#(
   parameter int LANES = 1,
   parameter int PIPE  = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [127:0]  in_data,
   input  logic          in_encrypt,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [127:0]  out_data,
   output logic          busy
);

   localparam int NCYC = ncyc(LANES);
   localparam int SW   = step_width(LANES);
   localparam int BW   = LANES * 8;

   generate
      if (!lanes_legal(LANES)) begin : g_bad_lanes
         $error("sbox_subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
      end
      if ((PIPE != 0) && (PIPE != 1)) begin : g_bad_pipe
         $error("sbox_subbytes_seq: PIPE must be 0 or 1");
      end
   endgenerate

   state_e         state;
   state_e         state_nxt;
   logic [SW-1:0]  step;
   logic           enc;
   logic [127:0]   work;
   logic [BW-1:0]  rd_bytes;
   logic [BW-1:0]  wr_bytes;
   logic [SW-1:0]  wr_step;
   logic           wb_en;
   logic [127:0]   merged;
   logic           last_step;
   logic           accept;

   assign last_step = (step == SW'(NCYC - 1));
   assign accept    = (state == IDLE) && in_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = RUN;
         end
         RUN: begin
            if (last_step) state_nxt = (PIPE != 0) ? DRAIN : DONE;
         end
         DRAIN: begin
            state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy     = (state != IDLE);
   // Gate the output so a half-substituted register is never visible
   assign out_data = (state == DONE) ? work : 128'd0;

   sbox_lane_bank #(
      .LANES (LANES),
      .SW    (SW)
   ) u_bank (
      .encrypt  (enc),
      .rd_step  (step),
      .work     (work),
      .wr_step  (wr_step),
      .wr_bytes (wr_bytes),
      .rd_bytes (rd_bytes),
      .merged   (merged)
   );

   generate
      if (PIPE != 0) begin : g_pipe
         logic [BW-1:0] pipe_bytes;
         logic [SW-1:0] pipe_step;
         logic          pipe_valid;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               pipe_bytes <= '0;
               pipe_step  <= '0;
               pipe_valid <= 1'b0;
            end else begin
               pipe_bytes <= rd_bytes;
               pipe_step  <= step;
               pipe_valid <= (state == RUN);
            end
         end

         assign wr_bytes = pipe_bytes;
         assign wr_step  = pipe_step;
         assign wb_en    = pipe_valid;
      end else begin : g_nopipe
         assign wr_bytes = rd_bytes;
         assign wr_step  = step;
         assign wb_en    = (state == RUN);
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work <= '0;
         enc  <= 1'b0;
         step <= '0;
      end else begin
         if (accept) begin
            work <= in_data;
            enc  <= in_encrypt;
            step <= '0;
         end else begin
            if (wb_en) work <= merged;
            if ((state == RUN) && !last_step) step <= step + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sbox_subbytes_seq.sv
// ============================================================================
// tb_sbox_subbytes_seq : directed checks on three configurations of the engine
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sbox_subbytes_seq;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid   [3];
   logic         in_encrypt [3];
   logic         out_ready  [3];
   logic         in_ready   [3];
   logic         out_valid  [3];
   logic         busy       [3];
   logic [127:0] in_data    [3];
   logic [127:0] out_data   [3];

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   sbox_subbytes_seq #(.LANES(1), .PIPE(0)) u_l1p0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_data(in_data[0]), .in_encrypt(in_encrypt[0]), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0]));

   sbox_subbytes_seq #(.LANES(4), .PIPE(1)) u_l4p1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_data(in_data[1]), .in_encrypt(in_encrypt[1]), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1]));

   sbox_subbytes_seq #(.LANES(16), .PIPE(0)) u_l16p0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .in_data(in_data[2]), .in_encrypt(in_encrypt[2]), .out_valid(out_valid[2]),
      .out_ready(out_ready[2]), .out_data(out_data[2]), .busy(busy[2]));

   localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Offer one state, measure cycles from accept to out_valid, check result and handshake
   task automatic run_op(input int i, input logic [127:0] data, input logic enc,
                         input logic [127:0] exp, input int lat, input string tag,
                         input bit toggle);
      int n;
      bit rdy_seen;
      out_ready[i] = 1'b1;
      @(negedge clk);
      in_valid[i]   = 1'b1;
      in_data[i]    = data;
      in_encrypt[i] = enc;
      chk({tag, "_ready_idle"}, 128'(in_ready[i]), 128'd1);
      @(posedge clk);
      #1;
      in_valid[i] = 1'b0;
      n = 0;
      rdy_seen = 1'b0;
      while (!out_valid[i] && n < 40) begin
         if (in_ready[i]) rdy_seen = 1'b1;
         if (toggle) begin
            in_data[i]    = ~in_data[i];
            in_encrypt[i] = ~in_encrypt[i];
         end
         @(posedge clk);
         #1;
         n++;
      end
      chk({tag, "_latency"}, 128'(n), 128'(lat));
      chk({tag, "_ready_busy"}, 128'(rdy_seen), 128'd0);
      chk({tag, "_busy"}, 128'(busy[i]), 128'd1);
      chk({tag, "_data"}, out_data[i], exp);
      @(posedge clk);
      #1;
      chk({tag, "_valid_drop"}, 128'(out_valid[i]), 128'd0);
      chk({tag, "_ready_back"}, 128'(in_ready[i]), 128'd1);
   endtask

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid[i]   = 1'b0;
         in_encrypt[i] = 1'b0;
         out_ready[i]  = 1'b0;
         in_data[i]    = 128'd0;
      end
      #12;
      for (int i = 0; i < 3; i++) begin
         chk("rst_in_ready", 128'(in_ready[i]), 128'd1);
         chk("rst_out_valid", 128'(out_valid[i]), 128'd0);
         chk("rst_busy", 128'(busy[i]), 128'd0);
         chk("rst_out_data", out_data[i], 128'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      run_op(0, FIPS_IN, 1'b1, FIPS_OUT, 16, "fwd_l1p0", 1'b0);
      run_op(1, FIPS_OUT, 1'b0, FIPS_IN, 5, "inv_l4p1", 1'b0);
      run_op(2, {16{8'h00}}, 1'b1, {16{8'h63}}, 1, "zero_l16", 1'b0);
      run_op(2, {16{8'hff}}, 1'b1, {16{8'h16}}, 1, "ones_l16", 1'b0);
      run_op(2, {16{8'h63}}, 1'b0, {16{8'h00}}, 1, "inv63_l16", 1'b0);

      // Backpressure with a second state held on the input while busy
      out_ready[2] = 1'b0;
      @(negedge clk);
      in_valid[2]   = 1'b1;
      in_data[2]    = {16{8'hff}};
      in_encrypt[2] = 1'b1;
      @(posedge clk);
      #1;
      in_data[2] = {16{8'h00}};
      @(posedge clk);
      #1;
      for (int c = 0; c < 20; c++) begin
         chk("bp_valid", 128'(out_valid[2]), 128'd1);
         chk("bp_data", out_data[2], {16{8'h16}});
         chk("bp_ready", 128'(in_ready[2]), 128'd0);
         @(posedge clk);
         #1;
      end
      out_ready[2] = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release_valid", 128'(out_valid[2]), 128'd0);
      chk("bp_release_ready", 128'(in_ready[2]), 128'd1);
      @(posedge clk);
      #1;
      in_valid[2] = 1'b0;
      chk("bp_second_busy", 128'(busy[2]), 128'd1);
      @(posedge clk);
      #1;
      chk("bp_second_valid", 128'(out_valid[2]), 128'd1);
      chk("bp_second_data", out_data[2], {16{8'h63}});
      @(posedge clk);
      #1;
      chk("bp_second_drop", 128'(out_valid[2]), 128'd0);

      run_op(0, FIPS_IN, 1'b1, FIPS_OUT, 16, "toggle_l1p0", 1'b1);

      // Asynchronous reset in the middle of step 7
      out_ready[0] = 1'b1;
      @(negedge clk);
      in_valid[0]   = 1'b1;
      in_data[0]    = FIPS_IN;
      in_encrypt[0] = 1'b1;
      @(posedge clk);
      #1;
      in_valid[0] = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", 128'(in_ready[0]), 128'd1);
      chk("mid_rst_out_valid", 128'(out_valid[0]), 128'd0);
      chk("mid_rst_busy", 128'(busy[0]), 128'd0);
      chk("mid_rst_out_data", out_data[0], 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(0, {16{8'h53}}, 1'b1, {16{8'hed}}, 16, "after_rst_l1p0", 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
